exec_sequencer: RTL and testbench

Multi-cycle fetch/decode/execute/writeback controller that sits directly upstream of the 4-bit ALU. It holds the program counter, the instruction register, a 4×4-bit register file and the zero flag. Each instruction runs as a four-state sequence: the block drives the ALU operands and the 3-bit ALU operation, then captures the ALU result and zero flag for writeback. Instruction memory is external, combinational and addressed by `pc_out`.

---
 rtl/exec_sequencer.sv | 215 +++++++++++++++++++++
 tb/tb_exec_sequencer.sv | 471 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/exec_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : exec_sequencer
// Brief    : Four-state fetch/decode/execute/writeback controller for a 4-bit
//            ALU. Define EXEC_SEQ_RETIRE_CNT_EN to add the 8-bit `retired`
//            instruction counter port.
// Revision : 1.0 - initial release
// ============================================================================
module exec_sequencer #(
    parameter logic [3:0] RESET_PC = 4'h0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       run,
    input  logic [7:0] instr_in,
    output logic [3:0] pc_out,
    output logic [3:0] alu_a,
    output logic [3:0] alu_b,
    output logic [2:0] alu_op,
    input  logic [3:0] alu_result,
    input  logic       alu_zero,
    output logic       z_flag,
    output logic       halted,
    output logic [1:0] state_out
`ifdef EXEC_SEQ_RETIRE_CNT_EN
    ,
    output logic [7:0] retired
`endif
);

    typedef enum logic [1:0] {
        ST_FETCH     = 2'b00,
        ST_DECODE    = 2'b01,
        ST_EXECUTE   = 2'b10,
        ST_WRITEBACK = 2'b11
    } state_t;

    localparam logic [3:0] c_OPC_ADD  = 4'h1;
    localparam logic [3:0] c_OPC_SUB  = 4'h2;
    localparam logic [3:0] c_OPC_AND  = 4'h3;
    localparam logic [3:0] c_OPC_OR   = 4'h4;
    localparam logic [3:0] c_OPC_XOR  = 4'h5;
    localparam logic [3:0] c_OPC_MOV  = 4'h6;
    localparam logic [3:0] c_OPC_LDI  = 4'h7;
    localparam logic [3:0] c_OPC_JZ   = 4'h8;
    localparam logic [3:0] c_OPC_JMP  = 4'h9;
    localparam logic [3:0] c_OPC_HALT = 4'hF;

    localparam logic [2:0] c_ALU_ADD  = 3'b000;
    localparam logic [2:0] c_ALU_SUB  = 3'b001;
    localparam logic [2:0] c_ALU_AND  = 3'b010;
    localparam logic [2:0] c_ALU_OR   = 3'b011;
    localparam logic [2:0] c_ALU_XOR  = 3'b100;
    localparam logic [2:0] c_ALU_PASS = 3'b101;

    state_t     state_q,  state_d;
    logic [3:0] pc_q,     pc_d;
    logic [7:0] ir_q,     ir_d;
    logic [3:0] rf_q [4];
    logic [3:0] rf_d [4];
    logic       z_q,      z_d;
    logic       halted_q, halted_d;
    logic [3:0] alu_a_q,  alu_a_d;
    logic [3:0] alu_b_q,  alu_b_d;
    logic [2:0] alu_op_q, alu_op_d;
    logic [3:0] result_q, result_d;
    logic       zero_q,   zero_d;

    logic [3:0] w_opcode;
    logic [1:0] w_rd;
    logic [1:0] w_rs;
    logic [1:0] w_dest;
    logic       w_is_alu;
    logic       w_take_jump;
    logic [2:0] w_alu_op;

    // Instruction decode is driven from IR, which is stable from DECODE to WRITEBACK.
    always_comb begin
        w_opcode    = ir_q[7:4];
        w_rd        = ir_q[3:2];
        w_rs        = ir_q[1:0];
        w_is_alu    = (w_opcode >= c_OPC_ADD) && (w_opcode <= c_OPC_LDI);
        w_dest      = (w_opcode == c_OPC_LDI) ? 2'd0 : w_rd;
        w_take_jump = (w_opcode == c_OPC_JMP) || ((w_opcode == c_OPC_JZ) && z_q);
        case (w_opcode)
            c_OPC_ADD: w_alu_op = c_ALU_ADD;
            c_OPC_SUB: w_alu_op = c_ALU_SUB;
            c_OPC_AND: w_alu_op = c_ALU_AND;
            c_OPC_OR:  w_alu_op = c_ALU_OR;
            c_OPC_XOR: w_alu_op = c_ALU_XOR;
            default:   w_alu_op = c_ALU_PASS;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        ir_d     = ir_q;
        rf_d     = rf_q;
        z_d      = z_q;
        halted_d = halted_q;
        alu_a_d  = alu_a_q;
        alu_b_d  = alu_b_q;
        alu_op_d = alu_op_q;
        result_d = result_q;
        zero_d   = zero_q;

        case (state_q)
            ST_FETCH: begin
                if (run) begin
                    ir_d    = instr_in;
                    state_d = ST_DECODE;
                end
            end

            ST_DECODE: begin
                if (w_is_alu) begin
                    if (w_opcode == c_OPC_MOV) begin
                        alu_a_d = rf_q[w_rs];
                    end else if (w_opcode == c_OPC_LDI) begin
                        alu_a_d = ir_q[3:0];
                    end else begin
                        alu_a_d = rf_q[w_rd];
                    end
                    alu_b_d  = rf_q[w_rs];
                    alu_op_d = w_alu_op;
                end else begin
                    alu_a_d  = 4'h0;
                    alu_b_d  = 4'h0;
                    alu_op_d = c_ALU_PASS;
                end
                state_d = ST_EXECUTE;
            end

            ST_EXECUTE: begin
                result_d = alu_result;
                zero_d   = alu_zero;
                state_d  = ST_WRITEBACK;
            end

            ST_WRITEBACK: begin
                // Once halted the machine parks here and only reset releases it.
                if (!halted_q) begin
                    if (w_is_alu) begin
                        rf_d[w_dest] = result_q;
                        z_d          = zero_q;
                    end
                    if (w_opcode == c_OPC_HALT) begin
                        halted_d = 1'b1;
                    end else begin
                        pc_d    = w_take_jump ? ir_q[3:0] : pc_q + 4'd1;
                        state_d = ST_FETCH;
                    end
                end
            end

            default: state_d = ST_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_FETCH;
            pc_q     <= RESET_PC;
            ir_q     <= 8'h00;
            rf_q     <= '{default: 4'h0};
            z_q      <= 1'b0;
            halted_q <= 1'b0;
            alu_a_q  <= 4'h0;
            alu_b_q  <= 4'h0;
            alu_op_q <= c_ALU_ADD;
            result_q <= 4'h0;
            zero_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            ir_q     <= ir_d;
            rf_q     <= rf_d;
            z_q      <= z_d;
            halted_q <= halted_d;
            alu_a_q  <= alu_a_d;
            alu_b_q  <= alu_b_d;
            alu_op_q <= alu_op_d;
            result_q <= result_d;
            zero_q   <= zero_d;
        end
    end

`ifdef EXEC_SEQ_RETIRE_CNT_EN
    logic [7:0] retired_q;

    // HALT is counted on its first WRITEBACK cycle only.
    always_ff @(posedge clk) begin
        if (rst) begin
            retired_q <= 8'h00;
        end else if ((state_q == ST_WRITEBACK) && !halted_q) begin
            retired_q <= retired_q + 8'd1;
        end
    end

    assign retired = retired_q;
`else
    // Counter and port are absent in this build.
`endif

    assign pc_out    = pc_q;
    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign alu_op    = alu_op_q;
    assign z_flag    = z_q;
    assign halted    = halted_q;
    assign state_out = state_q;

endmodule
`default_nettype wire

// File: tb/tb_exec_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_exec_sequencer
// Brief    : Self-checking bench for exec_sequencer against an instruction-level
//            reference model. Honours EXEC_SEQ_RETIRE_CNT_EN when defined.
// Revision : 1.0 - initial release
// ============================================================================
module tb_exec_sequencer;

    localparam logic [3:0] RESET_PC = 4'h0;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       run = 1'b0;
    logic [7:0] instr_in;
    logic [3:0] pc_out;
    logic [3:0] alu_a;
    logic [3:0] alu_b;
    logic [2:0] alu_op;
    logic [3:0] alu_result;
    logic       alu_zero;
    logic       z_flag;
    logic       halted;
    logic [1:0] state_out;
`ifdef EXEC_SEQ_RETIRE_CNT_EN
    logic [7:0] retired;
`endif

    logic [7:0] imem [16];
    int         checks = 0;
    int         errors = 0;

    // Architectural reference state
    logic [3:0] m_r [4];
    logic [3:0] m_pc;
    logic       m_z;
    logic       m_halt;
    logic [7:0] m_ret;

    exec_sequencer #(.RESET_PC(RESET_PC)) dut (
        .clk        (clk),
        .rst        (rst),
        .run        (run),
        .instr_in   (instr_in),
        .pc_out     (pc_out),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_op     (alu_op),
        .alu_result (alu_result),
        .alu_zero   (alu_zero),
        .z_flag     (z_flag),
        .halted     (halted),
        .state_out  (state_out)
`ifdef EXEC_SEQ_RETIRE_CNT_EN
        ,
        .retired    (retired)
`endif
    );

    always #5 clk = ~clk;

    assign instr_in = imem[pc_out];

    always_comb begin
        alu_result = 4'h0;
        case (alu_op)
            3'b000: alu_result = alu_a + alu_b;
            3'b001: alu_result = alu_a - alu_b;
            3'b010: alu_result = alu_a & alu_b;
            3'b011: alu_result = alu_a | alu_b;
            3'b100: alu_result = alu_a ^ alu_b;
            3'b101: alu_result = alu_a;
            default: alu_result = 4'h0;
        endcase
    end
    assign alu_zero = (alu_result == 4'h0);

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset;
        for (int i = 0; i < 4; i++) m_r[i] = 4'h0;
        m_pc   = RESET_PC;
        m_z    = 1'b0;
        m_halt = 1'b0;
        m_ret  = 8'h00;
    endtask

    task automatic do_reset;
        rst = 1'b1;
        run = 1'b0;
        tick;
        tick;
        rst = 1'b0;
        model_reset;
    endtask

    // Executes one instruction architecturally; returns the operands the ALU should see.
    task automatic model_step(input logic [7:0] ins, output logic [3:0] ea,
                              output logic [3:0] eb, output logic [2:0] eop);
        logic [3:0] opc;
        int         rd;
        int         rs;
        logic [3:0] res;
        opc = ins[7:4];
        rd  = int'(ins[3:2]);
        rs  = int'(ins[1:0]);
        ea  = 4'h0;
        eb  = 4'h0;
        eop = 3'b101;
        res = 4'h0;
        if (opc >= 4'h1 && opc <= 4'h5) begin
            ea = m_r[rd];
            eb = m_r[rs];
            case (opc)
                4'h1: begin eop = 3'b000; res = 4'(m_r[rd] + m_r[rs]); end
                4'h2: begin eop = 3'b001; res = 4'(m_r[rd] - m_r[rs]); end
                4'h3: begin eop = 3'b010; res = m_r[rd] & m_r[rs]; end
                4'h4: begin eop = 3'b011; res = m_r[rd] | m_r[rs]; end
                default: begin eop = 3'b100; res = m_r[rd] ^ m_r[rs]; end
            endcase
            m_r[rd] = res;
            m_z     = (res == 4'h0);
            m_pc    = 4'(m_pc + 1);
        end else if (opc == 4'h6) begin
            ea      = m_r[rs];
            eb      = m_r[rs];
            m_r[rd] = m_r[rs];
            m_z     = (m_r[rs] == 4'h0);
            m_pc    = 4'(m_pc + 1);
        end else if (opc == 4'h7) begin
            ea     = ins[3:0];
            eb     = m_r[rs];
            m_r[0] = ins[3:0];
            m_z    = (ins[3:0] == 4'h0);
            m_pc   = 4'(m_pc + 1);
        end else if (opc == 4'h8) begin
            m_pc = m_z ? ins[3:0] : 4'(m_pc + 1);
        end else if (opc == 4'h9) begin
            m_pc = ins[3:0];
        end else if (opc == 4'hF) begin
            m_halt = 1'b1;
        end else begin
            m_pc = 4'(m_pc + 1);
        end
        m_ret = m_ret + 8'd1;
    endtask

    // Runs one instruction from FETCH with run=1, capturing the ALU drive in EXECUTE.
    task automatic step_instr(output logic [3:0] oa, output logic [3:0] ob,
                              output logic [2:0] oop, output logic [1:0] ost);
        tick;
        tick;
        ost = state_out;
        oa  = alu_a;
        ob  = alu_b;
        oop = alu_op;
        tick;
        tick;
    endtask

    task automatic test_reset;
        run = 1'b1;
        tick;
        tick;
        tick;
        do_reset;
        checks++;
        if ({pc_out, state_out} !== {RESET_PC, 2'b00}) begin
            errors++;
            $display("FAIL reset_pc_state: got %h/%b expected %h/00", pc_out, state_out, RESET_PC);
        end
        checks++;
        if ({alu_a, alu_b, alu_op} !== 11'h000) begin
            errors++;
            $display("FAIL reset_alu: got a=%h b=%h op=%b expected 0/0/000", alu_a, alu_b, alu_op);
        end
        checks++;
        if ({z_flag, halted} !== 2'b00) begin
            errors++;
            $display("FAIL reset_flags: got z=%b halted=%b expected 0/0", z_flag, halted);
        end
`ifdef EXEC_SEQ_RETIRE_CNT_EN
        checks++;
        if (retired !== 8'h00) begin
            errors++;
            $display("FAIL reset_retired: got %0d expected 0", retired);
        end
`endif
    endtask

    task automatic test_ldi_halt;
        logic [3:0] oa, ob;
        logic [2:0] oop;
        logic [1:0] ost;
        do_reset;
        imem[0] = 8'h75;
        imem[1] = 8'hF0;
        run = 1'b1;
        step_instr(oa, ob, oop, ost);
        checks++;
        if ({ost, oa, oop} !== {2'b10, 4'h5, 3'b101}) begin
            errors++;
            $display("FAIL ldi_exec: got st=%b a=%h op=%b expected 10/5/101", ost, oa, oop);
        end
        step_instr(oa, ob, oop, ost);
        checks++;
        if ({halted, z_flag, pc_out, state_out} !== {1'b1, 1'b0, 4'h1, 2'b11}) begin
            errors++;
            $display("FAIL halt_after_8: got h=%b z=%b pc=%h st=%b expected 1/0/1/11",
                     halted, z_flag, pc_out, state_out);
        end
        for (int i = 0; i < 6; i++) tick;
        checks++;
        if ({halted, pc_out, state_out} !== {1'b1, 4'h1, 2'b11}) begin
            errors++;
            $display("FAIL halt_sticky: got h=%b pc=%h st=%b expected 1/1/11", halted, pc_out, state_out);
        end
    endtask

    task automatic test_sub_jz;
        logic [3:0] oa, ob;
        logic [2:0] oop;
        logic [1:0] ost;
        do_reset;
        imem[0] = 8'h73;   // LDI 3
        imem[1] = 8'h64;   // MOV R1,R0
        imem[2] = 8'h24;   // SUB R1,R0
        imem[3] = 8'h84;   // JZ 4 (taken)
        imem[4] = 8'h14;   // ADD R1,R0 -> 3, clears Z
        imem[5] = 8'h8C;   // JZ 12 (not taken)
        imem[6] = 8'hF0;
        run = 1'b1;
        step_instr(oa, ob, oop, ost);
        step_instr(oa, ob, oop, ost);
        checks++;
        if ({oa, ob, oop} !== {4'h3, 4'h3, 3'b101}) begin
            errors++;
            $display("FAIL mov_exec: got a=%h b=%h op=%b expected 3/3/101", oa, ob, oop);
        end
        step_instr(oa, ob, oop, ost);
        checks++;
        if ({ost, oa, ob, oop} !== {2'b10, 4'h3, 4'h3, 3'b001}) begin
            errors++;
            $display("FAIL sub_exec: got st=%b a=%h b=%h op=%b expected 10/3/3/001", ost, oa, ob, oop);
        end
        checks++;
        if ({z_flag, pc_out} !== {1'b1, 4'h3}) begin
            errors++;
            $display("FAIL sub_zero: got z=%b pc=%h expected 1/3", z_flag, pc_out);
        end
        step_instr(oa, ob, oop, ost);
        checks++;
        if ({z_flag, pc_out, oa, ob, oop} !== {1'b1, 4'h4, 4'h0, 4'h0, 3'b101}) begin
            errors++;
            $display("FAIL jz_taken: got z=%b pc=%h a=%h b=%h op=%b expected 1/4/0/0/101",
                     z_flag, pc_out, oa, ob, oop);
        end
        step_instr(oa, ob, oop, ost);
        checks++;
        if ({z_flag, oa, ob, oop} !== {1'b0, 4'h0, 4'h3, 3'b000}) begin
            errors++;
            $display("FAIL add_after_sub: got z=%b a=%h b=%h op=%b expected 0/0/3/000", z_flag, oa, ob, oop);
        end
        step_instr(oa, ob, oop, ost);
        checks++;
        if (pc_out !== 4'h6) begin
            errors++;
            $display("FAIL jz_not_taken: got pc=%h expected 6", pc_out);
        end
    endtask

    task automatic test_pc_wrap;
        logic [3:0] oa, ob;
        logic [2:0] oop;
        logic [1:0] ost;
        logic [3:0] pcs [3];
        do_reset;
        imem[0]  = 8'h70;   // LDI 0 sets Z
        imem[1]  = 8'h9E;   // JMP 14
        imem[14] = 8'h00;
        imem[15] = 8'hC5;   // undefined opcode behaves as NOP
        run = 1'b1;
        step_instr(oa, ob, oop, ost);
        step_instr(oa, ob, oop, ost);
        imem[0] = 8'hA7;
        pcs[0] = pc_out;
        step_instr(oa, ob, oop, ost);
        pcs[1] = pc_out;
        step_instr(oa, ob, oop, ost);
        pcs[2] = pc_out;
        checks++;
        if ({pcs[0], pcs[1], pcs[2]} !== {4'hE, 4'hF, 4'h0}) begin
            errors++;
            $display("FAIL pc_wrap: got %h,%h,%h expected e,f,0", pcs[0], pcs[1], pcs[2]);
        end
        checks++;
        if ({oa, ob, oop} !== {4'h0, 4'h0, 3'b101}) begin
            errors++;
            $display("FAIL nop_alu_drive: got a=%h b=%h op=%b expected 0/0/101", oa, ob, oop);
        end
        step_instr(oa, ob, oop, ost);
        checks++;
        if ({pc_out, z_flag} !== {4'h1, 1'b1}) begin
            errors++;
            $display("FAIL nop_keeps_z: got pc=%h z=%b expected 1/1", pc_out, z_flag);
        end
    endtask

    task automatic test_reset_mid;
        logic [3:0] oa, ob;
        logic [2:0] oop;
        logic [1:0] ost;
        do_reset;
        imem[0] = 8'h77;   // LDI 7
        imem[1] = 8'h10;   // ADD R0,R0
        run = 1'b1;
        step_instr(oa, ob, oop, ost);
        tick;
        tick;
        checks++;
        if ({state_out, alu_a, alu_b} !== {2'b10, 4'h7, 4'h7}) begin
            errors++;
            $display("FAIL add_exec_pre_rst: got st=%b a=%h b=%h expected 10/7/7", state_out, alu_a, alu_b);
        end
        rst = 1'b1;
        tick;
        rst = 1'b0;
        model_reset;
        checks++;
        if ({state_out, pc_out, alu_a, alu_b, alu_op, z_flag} !== {2'b00, RESET_PC, 11'h000, 1'b0}) begin
            errors++;
            $display("FAIL mid_reset: got st=%b pc=%h a=%h b=%h op=%b z=%b expected 00/%h/0/0/000/0",
                     state_out, pc_out, alu_a, alu_b, alu_op, z_flag, RESET_PC);
        end
        imem[0] = 8'h40;   // OR R0,R0 exposes R0
        step_instr(oa, ob, oop, ost);
        checks++;
        if ({oa, ob, oop, z_flag, pc_out} !== {4'h0, 4'h0, 3'b011, 1'b1, 4'h1}) begin
            errors++;
            $display("FAIL no_writeback: got a=%h b=%h op=%b z=%b pc=%h expected 0/0/011/1/1",
                     oa, ob, oop, z_flag, pc_out);
        end
    endtask

    task automatic test_run_hold;
        int bad;
        do_reset;
        imem[0] = 8'h00;
        imem[1] = 8'h00;
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            tick;
            if ({state_out, pc_out} !== {2'b00, RESET_PC}) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL run_low_hold: got %0d cycles left FETCH expected 0", bad);
        end
        run = 1'b1;
        tick;
        run = 1'b0;
        tick;
        tick;
        tick;
        checks++;
        if ({state_out, pc_out} !== {2'b00, 4'h1}) begin
            errors++;
            $display("FAIL run_drop_midinstr: got st=%b pc=%h expected 00/1", state_out, pc_out);
        end
        tick;
        tick;
        checks++;
        if ({state_out, pc_out} !== {2'b00, 4'h1}) begin
            errors++;
            $display("FAIL run_low_after: got st=%b pc=%h expected 00/1", state_out, pc_out);
        end
    endtask

`ifdef EXEC_SEQ_RETIRE_CNT_EN
    task automatic test_retire;
        logic [3:0] oa, ob;
        logic [2:0] oop;
        logic [1:0] ost;
        do_reset;
        imem[0] = 8'h00;
        imem[1] = 8'hA3;
        imem[2] = 8'h0F;
        imem[3] = 8'hF0;
        run = 1'b1;
        for (int i = 0; i < 4; i++) step_instr(oa, ob, oop, ost);
        checks++;
        if (retired !== 8'd4) begin
            errors++;
            $display("FAIL retire_count: got %0d expected 4", retired);
        end
        for (int i = 0; i < 6; i++) tick;
        checks++;
        if ({retired, state_out} !== {8'd4, 2'b11}) begin
            errors++;
            $display("FAIL retire_halted: got %0d st=%b expected 4/11", retired, state_out);
        end
    endtask
`endif

    task automatic test_random;
        logic [3:0] oa, ob, ea, eb;
        logic [2:0] oop, eop;
        logic [1:0] ost;
        logic [7:0] ins;
        int         r;
        logic [3:0] opc;
        for (int round = 0; round < 8; round++) begin
            do_reset;
            for (int i = 0; i < 16; i++) begin
                r = int'($urandom_range(0, 19));
                if (r < 14)      opc = 4'(r % 9 + 1);
                else if (r < 18) opc = 4'($urandom_range(0, 14));
                else             opc = 4'hF;
                imem[i] = {opc, 4'($urandom_range(0, 15))};
            end
            run = 1'b1;
            for (int n = 0; n < 40 && !m_halt; n++) begin
                ins = imem[m_pc];
                model_step(ins, ea, eb, eop);
                step_instr(oa, ob, oop, ost);
                checks++;
                if ({ost, oa, ob, oop} !== {2'b10, ea, eb, eop}) begin
                    errors++;
                    $display("FAIL rand_exec ins=%h: got st=%b a=%h b=%h op=%b expected 10/%h/%h/%b",
                             ins, ost, oa, ob, oop, ea, eb, eop);
                end
                checks++;
                if ({pc_out, z_flag, halted, state_out} !== {m_pc, m_z, m_halt, (m_halt ? 2'b11 : 2'b00)}) begin
                    errors++;
                    $display("FAIL rand_arch ins=%h: got pc=%h z=%b h=%b st=%b expected %h/%b/%b",
                             ins, pc_out, z_flag, halted, state_out, m_pc, m_z, m_halt);
                end
`ifdef EXEC_SEQ_RETIRE_CNT_EN
                checks++;
                if (retired !== m_ret) begin
                    errors++;
                    $display("FAIL rand_retired: got %0d expected %0d", retired, m_ret);
                end
`endif
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) imem[i] = 8'h00;
        model_reset;
        test_reset;
        test_ldi_halt;
        test_sub_jz;
        test_pc_wrap;
        test_reset_mid;
        test_run_hold;
`ifdef EXEC_SEQ_RETIRE_CNT_EN
        test_retire;
`endif
        test_random;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
